score_display: RTL and testbench
================================

# score_display

Downstream consumer of the score tracker. It converts the 7-bit binary current score and high score into BCD digits with a sequential double-dabble engine. It then time-multiplexes six seven-segment digits (current score ×3, high score ×3) onto a shared segment bus. While the game-complete flag is set, it blinks the current-score digits.

## Interface
- REFRESH_DIV, 1000: clock cycles each digit stays selected (≥2).
- BLINK_SCANS, 32: full 6-digit scans per blink half-period (≥1).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- currScore  input  7  current score, binary 0..127.
- highScore  input  7  high score, binary 0..127.
- isGameComplete  input  1  game-over flag; enables blinking.
- seg  output  7  segments {a,b,c,d,e,f,g}, active-high, registered.
- digitSel  output  6  one-hot digit enable, active-high, registered.
- busy  output  1  high while a conversion is in progress.

## Operation
- Snapshot registers hold the last converted currScore/highScore. In IDLE, if either input differs from its snapshot, the block loads both inputs into the snapshots and shift registers and enters SHIFT.
- FSM states:
  - IDLE -> SHIFT on mismatch.
  - SHIFT runs exactly 7 iterations. Each iteration adds 3 to any BCD nibble ≥5, then shifts left by 1. Both scores convert in parallel.
  - SHIFT -> UPDATE. UPDATE copies the results to the display BCD registers.
  - UPDATE -> IDLE.
- busy = 1 in SHIFT and UPDATE.
- Inputs that change during SHIFT/UPDATE are ignored. The mismatch check in the next IDLE cycle picks them up. No update is lost; only the final stable value is guaranteed to be displayed.
- BCD width: 3 nibbles per score. The hundreds digit is only 0 or 1, and values never exceed 127.
- Digit map: 0 = curr ones, 1 = curr tens, 2 = curr hundreds, 3 = high ones, 4 = high tens, 5 = high hundreds.
- Leading-zero blanking (seg = 0):
  - Hundreds digit is blanked if it is 0.
  - Tens digit is blanked if both hundreds and tens are 0.
  - Ones digit is always shown.
- Glyphs:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
- Scan:
  - refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0->1->…->5->0.
  - A scan counter increments on each index wrap 5->0. When it reaches BLINK_SCANS-1 it wraps, and blinkPhase toggles.
- Blink: when isGameComplete = 1 and blinkPhase = 1, seg = 0 for digits 0..2. High-score digits are never blinked. When isGameComplete = 0, the display is unaffected regardless of blinkPhase.

## Timing
- Reset values (hold for every cycle rst is high):
  - seg = 0, digitSel = 0, busy = 0.
  - FSM = IDLE; snapshots, shift registers and display BCD registers = 0.
  - refresh counter, digit index, scan counter and blinkPhase = 0.
- rst mid-conversion aborts it. The display returns to showing 0/0.
- First cycle after rst deasserts: digitSel = 000001 and seg = glyph 0 (ones digit).
- Output pipeline: seg and digitSel are registered from the index and BCD state of the previous cycle, giving 1 cycle of latency.
- Conversion latency: input change visible at edge N is detected at edge N+1 (IDLE to SHIFT). SHIFT occupies N+1..N+7, UPDATE is N+8, and the new BCD value reaches the seg bus no later than edge N+9 for the selected digit.
- Worst case (change arrives just after a load): the value is displayed within 18 cycles.
- Each digit is selected for exactly REFRESH_DIV cycles. digitSel is never 0 and never multi-hot outside reset.

## Structure
- Shared package score_pkg:
  - SCORE_W = 7 and BCD_DIGITS = 3.
  - typedef bcd3_t (3×4-bit).
  - FSM enum conv_state_t {IDLE, SHIFT, UPDATE}.
  - seven-segment glyph constants.
- Sub-module bin2bcd_seq: one sequential double-dabble converter with start/done. Instantiate it twice, or share its FSM with two datapaths. The top level holds the scan and blink logic.

## Test plan
- Reset: hold rst for 3 cycles -> seg = 0, digitSel = 0, busy = 0. After release, digitSel = 000001 and seg = 1111110.
- currScore = 42, highScore = 127 (use REFRESH_DIV = 2):
  - busy = 1 for exactly 8 cycles.
  - Digit 0 = 1101101 and digit 1 = 0110011; digit 2 is blank.
  - Digits 3/4/5 = 1110000 / 1101101 / 0110000.
- currScore 5 -> 9 during SHIFT -> first shows 5, then a second conversion follows, and digit 0 = 1111011 within 18 cycles of the change.
- Blanking: currScore = 100 -> digits 2/1/0 show 1, 0, 0. currScore = 7 -> digits 1 and 2 are blank.
- isGameComplete = 1 with BLINK_SCANS = 1 -> digits 0..2 alternate between glyph and 0 on every full scan; digits 3..5 stay steady. Deasserting isGameComplete restores the display immediately.
- rst asserted during SHIFT -> next cycle busy = 0 and all state returns to reset values. With inputs still nonzero, a fresh conversion starts after release.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types, constants and helpers for the score display slice.
// Provides widths, BCD type, converter FSM states and segment glyphs.
package score_pkg;

   localparam int SCORE_W    = 7;
   localparam int BCD_DIGITS = 3;
   localparam int SR_W       = BCD_DIGITS * 4 + SCORE_W;

   typedef logic [BCD_DIGITS-1:0][3:0] bcd3_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE
   } conv_state_t;

   localparam logic [6:0] GLYPH_0 = 7'b1111110;
   localparam logic [6:0] GLYPH_1 = 7'b0110000;
   localparam logic [6:0] GLYPH_2 = 7'b1101101;
   localparam logic [6:0] GLYPH_3 = 7'b1111001;
   localparam logic [6:0] GLYPH_4 = 7'b0110011;
   localparam logic [6:0] GLYPH_5 = 7'b1011011;
   localparam logic [6:0] GLYPH_6 = 7'b1011111;
   localparam logic [6:0] GLYPH_7 = 7'b1110000;
   localparam logic [6:0] GLYPH_8 = 7'b1111111;
   localparam logic [6:0] GLYPH_9 = 7'b1111011;

   function automatic logic [6:0] seg7(
      input logic [3:0] d
   );
      logic [6:0] g;
      case (d)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = '0;
      endcase
      return g;
   endfunction

   // One double-dabble iteration on {bcd, bin}: correct
   // every nibble >= 5, then shift the whole word left.
   function automatic logic [SR_W-1:0] dd_step(
      input logic [SR_W-1:0] v
   );
      logic [SR_W-1:0] t;
      t = v;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (t[SCORE_W+4*d +: 4] >= 4'd5)
            t[SCORE_W+4*d +: 4] =
               t[SCORE_W+4*d +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

endpackage

// File: rtl/score_display_if.sv
// Score display bus: scores and game flag in, segments/select/busy out.
// master drives scores (tracker side), slave is the display block.
interface score_display_if;
   import score_pkg::*;

   logic [SCORE_W-1:0] currScore;
   logic [SCORE_W-1:0] highScore;
   logic               isGameComplete;
   logic [6:0]         seg;
   logic [5:0]         digitSel;
   logic               busy;

   modport master (
      output currScore,
      output highScore,
      output isGameComplete,
      input  seg,
      input  digitSel,
      input  busy
   );

   modport slave (
      input  currScore,
      input  highScore,
      input  isGameComplete,
      output seg,
      output digitSel,
      output busy
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary score to 3 BCD digits in 7 steps.
// Ports: clk, rst, start (load bin), bin, bcd (result), done (last step).
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output bcd3_t              bcd,
   output logic               done
);

   logic [SR_W-1:0] sr;
   logic [2:0]      it;
   logic            run;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         it  <= '0;
         run <= 1'b0;
      end else if (start) begin
         sr  <= {{(BCD_DIGITS*4){1'b0}}, bin};
         it  <= '0;
         run <= 1'b1;
      end else if (run) begin
         sr <= dd_step(sr);
         if (it == 3'(SCORE_W - 1))
            run <= 1'b0;
         else
            it <= it + 3'd1;
      end
   end

   // High while the final iteration is being applied.
   assign done = run && (it == 3'(SCORE_W - 1));
   assign bcd  = sr[SR_W-1 -: BCD_DIGITS*4];

endmodule

// File: rtl/score_display.sv
// Six-digit multiplexed display of current/high score with blink.
// Ports: clk, rst, bus (slave: scores/flag in, seg/digitSel/busy out).
module score_display
   import score_pkg::*;
#(
   parameter int REFRESH_DIV = 1000,
   parameter int BLINK_SCANS = 32
) (
   input  logic      clk,
   input  logic      rst,
   score_display_if.slave bus
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int SW =
      (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   conv_state_t        state;
   logic [SCORE_W-1:0] curr_snap;
   logic [SCORE_W-1:0] high_snap;
   bcd3_t              curr_disp;
   bcd3_t              high_disp;
   bcd3_t              curr_conv;
   bcd3_t              high_conv;
   bcd3_t              curr_show;
   bcd3_t              high_show;
   logic               start;
   logic               curr_done;
   logic               high_done;
   logic               conv_done;
   logic               busy_r;

   logic [RW-1:0]      ref_cnt;
   logic [2:0]         dig_idx;
   logic [SW-1:0]      scan_cnt;
   logic               blink_phase;

   logic [3:0]         nib;
   logic               blank;
   logic [6:0]         seg_nxt;
   logic [5:0]         sel_nxt;
   logic [6:0]         seg_r;
   logic [5:0]         sel_r;

   assign start = (state == IDLE) &&
      ((bus.currScore != curr_snap) ||
       (bus.highScore != high_snap));

   bin2bcd_seq u_curr (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bus.currScore),
      .bcd   (curr_conv),
      .done  (curr_done)
   );

   bin2bcd_seq u_high (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bus.highScore),
      .bcd   (high_conv),
      .done  (high_done)
   );

   assign conv_done = curr_done & high_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         curr_snap <= '0;
         high_snap <= '0;
         curr_disp <= '0;
         high_disp <= '0;
         busy_r    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  curr_snap <= bus.currScore;
                  high_snap <= bus.highScore;
                  busy_r    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (conv_done)
                  state <= UPDATE;
            end
            UPDATE: begin
               curr_disp <= curr_conv;
               high_disp <= high_conv;
               busy_r    <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // While UPDATE writes the display registers, feed the
   // fresh result straight to the segment pipeline so the
   // new value lands on the bus on the same edge.
   assign curr_show =
      (state == UPDATE) ? curr_conv : curr_disp;
   assign high_show =
      (state == UPDATE) ? high_conv : high_disp;

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt     <= '0;
         dig_idx     <= '0;
         scan_cnt    <= '0;
         blink_phase <= 1'b0;
      end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
         ref_cnt <= '0;
         if (dig_idx == 3'd5) begin
            dig_idx <= '0;
            if (scan_cnt == SW'(BLINK_SCANS - 1)) begin
               scan_cnt    <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               scan_cnt <= scan_cnt + SW'(1);
            end
         end else begin
            dig_idx <= dig_idx + 3'd1;
         end
      end else begin
         ref_cnt <= ref_cnt + RW'(1);
      end
   end

   always_comb begin
      nib   = '0;
      blank = 1'b0;
      case (dig_idx)
         3'd0: nib = curr_show[0];
         3'd1: begin
            nib   = curr_show[1];
            blank = (curr_show[2] == 4'd0) &&
                    (curr_show[1] == 4'd0);
         end
         3'd2: begin
            nib   = curr_show[2];
            blank = (curr_show[2] == 4'd0);
         end
         3'd3: nib = high_show[0];
         3'd4: begin
            nib   = high_show[1];
            blank = (high_show[2] == 4'd0) &&
                    (high_show[1] == 4'd0);
         end
         3'd5: begin
            nib   = high_show[2];
            blank = (high_show[2] == 4'd0);
         end
         default: nib = '0;
      endcase
      if ((dig_idx < 3'd3) && bus.isGameComplete &&
          blink_phase)
         blank = 1'b1;
      seg_nxt = blank ? 7'd0 : seg7(nib);
      sel_nxt = 6'd1 << dig_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_r <= '0;
         sel_r <= '0;
      end else begin
         seg_r <= seg_nxt;
         sel_r <= sel_nxt;
      end
   end

   assign bus.seg      = seg_r;
   assign bus.digitSel = sel_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a decimal reference model.
// Drives random and directed scores; checks scan, blanking and blink.
module tb_score_display;

   localparam int RD = 2;
   localparam int BS = 1;

   logic tb_clk = 1'b0;
   logic rst    = 1'b1;

   always #5 tb_clk = ~tb_clk;

   score_display_if bus ();

   score_display #(
      .REFRESH_DIV (RD),
      .BLINK_SCANS (BS)
   ) dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int k = 0;
   int disp_curr = 0;
   int disp_high = 0;
   logic [6:0] glyph_tab [10];
   logic [6:0] dig [6];

   // Output edges since reset release.
   always @(posedge tb_clk) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int idx);
      int v, d, h, t, o, dv;
      logic bl;
      v  = (idx < 3) ? disp_curr : disp_high;
      d  = idx % 3;
      h  = v / 100;
      t  = (v / 10) % 10;
      o  = v % 10;
      bl = 1'b0;
      dv = (d == 0) ? o : (d == 1) ? t : h;
      if (d == 2 && h == 0) bl = 1'b1;
      if (d == 1 && h == 0 && t == 0) bl = 1'b1;
      if (idx < 3 && bus.isGameComplete &&
          (((k - 1) / (RD * 6 * BS)) % 2) == 1)
         bl = 1'b1;
      return bl ? 7'd0 : glyph_tab[dv];
   endfunction

   task automatic scan(input string tag, input int n);
      int idx;
      repeat (n) begin
         @(negedge tb_clk);
         idx = ((k - 1) / RD) % 6;
         chk({tag, "_sel"}, 32'(bus.digitSel),
             32'(6'd1 << idx));
         chk({tag, "_seg"}, 32'(bus.seg),
             32'(exp_seg(idx)));
      end
   endtask

   task automatic collect();
      repeat (6 * RD) begin
         @(negedge tb_clk);
         for (int i = 0; i < 6; i++)
            if (bus.digitSel[i]) dig[i] = bus.seg;
      end
   endtask

   task automatic apply(input int c, input int h);
      bus.currScore = 7'(c);
      bus.highScore = 7'(h);
      repeat (20) @(negedge tb_clk);
      disp_curr = c;
      disp_high = h;
   endtask

   initial begin
      int bcnt;
      int rises;
      logic prev;
      glyph_tab = '{7'b1111110, 7'b0110000, 7'b1101101,
                    7'b1111001, 7'b0110011, 7'b1011011,
                    7'b1011111, 7'b1110000, 7'b1111111,
                    7'b1111011};
      bus.currScore      = '0;
      bus.highScore      = '0;
      bus.isGameComplete = 1'b0;
      rst                = 1'b1;

      repeat (3) begin
         @(negedge tb_clk);
         chk("rst_seg",  32'(bus.seg), 32'd0);
         chk("rst_sel",  32'(bus.digitSel), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
      end
      rst = 1'b0;
      @(negedge tb_clk);
      chk("rel_sel", 32'(bus.digitSel), 32'b000001);
      chk("rel_seg", 32'(bus.seg), 32'b1111110);

      // 42 / 127: busy length and glyphs
      bus.currScore = 7'd42;
      bus.highScore = 7'd127;
      bcnt = 0;
      repeat (12) begin
         @(negedge tb_clk);
         if (bus.busy) bcnt++;
      end
      chk("busy_len", 32'(bcnt), 32'd8);
      disp_curr = 42;
      disp_high = 127;
      collect();
      chk("d0_42",  32'(dig[0]), 32'b1101101);
      chk("d1_42",  32'(dig[1]), 32'b0110011);
      chk("d2_42",  32'(dig[2]), 32'd0);
      chk("d3_127", 32'(dig[3]), 32'b1110000);
      chk("d4_127", 32'(dig[4]), 32'b1101101);
      chk("d5_127", 32'(dig[5]), 32'b0110000);
      scan("s42", 12);

      // change during SHIFT: two conversions, 9 shown
      bus.currScore = 7'd5;
      rises = 0;
      prev  = bus.busy;
      for (int c = 0; c < 21; c++) begin
         @(negedge tb_clk);
         if (bus.busy && !prev) rises++;
         prev = bus.busy;
         if (c == 2) begin
            chk("mid_busy", 32'(bus.busy), 32'd1);
            bus.currScore = 7'd9;
         end
      end
      chk("two_conv", 32'(rises), 32'd2);
      chk("idle_after", 32'(bus.busy), 32'd0);
      disp_curr = 9;
      scan("s9", 12);

      // blanking
      apply(100, 127);
      collect();
      chk("d2_100", 32'(dig[2]), 32'b0110000);
      chk("d1_100", 32'(dig[1]), 32'b1111110);
      chk("d0_100", 32'(dig[0]), 32'b1111110);
      apply(7, 3);
      collect();
      chk("d1_7", 32'(dig[1]), 32'd0);
      chk("d2_7", 32'(dig[2]), 32'd0);
      chk("d0_7", 32'(dig[0]), 32'b1110000);
      scan("s7", 12);

      // randomized scores and game flag
      for (int r = 0; r < 10; r++) begin
         bus.isGameComplete = 1'($urandom_range(1, 0));
         apply(int'($urandom_range(127, 0)),
               int'($urandom_range(127, 0)));
         scan("rnd", 12);
      end

      // blink across several scans, then release
      bus.isGameComplete = 1'b1;
      apply(88, 64);
      scan("blink", 60);
      bus.isGameComplete = 1'b0;
      scan("unblink", 12);

      // reset during SHIFT
      bus.currScore = 7'd33;
      bus.highScore = 7'd81;
      repeat (3) @(negedge tb_clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge tb_clk);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_seg",  32'(bus.seg), 32'd0);
      chk("mrst_sel",  32'(bus.digitSel), 32'd0);
      rst = 1'b0;
      disp_curr = 0;
      disp_high = 0;
      @(negedge tb_clk);
      chk("post_busy", 32'(bus.busy), 32'd1);
      chk("post_sel",  32'(bus.digitSel), 32'b000001);
      chk("post_seg",  32'(bus.seg), 32'b1111110);
      repeat (19) @(negedge tb_clk);
      disp_curr = 33;
      disp_high = 81;
      scan("s33", 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
